uart_responder: RTL and testbench



---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_responder_if.sv | 17 +
 rtl/uart_rx_fifo.sv | 52 +++++
 rtl/uart_responder.sv | 135 +++++++++++++
 tb/tb_uart_responder.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame constants, FSM state type and bit-counter width helper.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic STOP_LEVEL = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    function automatic int cnt_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_responder_if.sv
// uart_responder_if: CPU-side UART IO strobes, data and status.
interface uart_responder_if;

    logic       uart0_wr;
    logic       uart0_rd;
    logic [7:0] uart_w;
    logic [7:0] uart0_data;
    logic       tx_busy;
    logic       rx_valid;
    logic       rx_overflow;

    modport master (output uart0_wr, uart0_rd, uart_w,
                    input  uart0_data, tx_busy, rx_valid, rx_overflow);
    modport slave  (input  uart0_wr, uart0_rd, uart_w,
                    output uart0_data, tx_busy, rx_valid, rx_overflow);

endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: RX byte FIFO with a registered head (0 when empty) and a one-cycle overflow pulse.
module uart_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       resetq,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] head,
    output logic       valid,
    output logic       overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wptr, rptr, wptr_d, rptr_d;
    logic [7:0]  head_d;
    logic        full, empty, do_push, do_pop;

    always_comb begin
        empty   = wptr == rptr;
        full    = wptr == {~rptr[AW], rptr[AW-1:0]};
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wptr_d  = do_push ? wptr + 1'b1 : wptr;
        rptr_d  = do_pop ? rptr + 1'b1 : rptr;
        // bypass the byte being written when it becomes the new head
        head_d  = wptr_d == rptr_d ? 8'h00 :
                  (do_push && wptr[AW-1:0] == rptr_d[AW-1:0]) ? din : mem[rptr_d[AW-1:0]];
    end

    always_ff @(posedge clk)
        if (do_push) mem[wptr[AW-1:0]] <= din;

    always_ff @(posedge clk or negedge resetq)
        if (!resetq) begin
            wptr     <= '0;
            rptr     <= '0;
            head     <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wptr     <= wptr_d;
            rptr     <= rptr_d;
            head     <= head_d;
            valid    <= wptr_d != rptr_d;
            overflow <= push && !do_push;
        end

endmodule

// File: rtl/uart_responder.sv
// uart_responder: 8N1 UART TX/RX behind the CPU UART strobes, RX bytes buffered in a FIFO.
// Define UART_TX_HOLD_EN to add a one-byte TX holding register.
module uart_responder
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int RX_DEPTH     = 16
) (
    input  logic             clk,
    input  logic             resetq,
    uart_responder_if.slave  bus,
    output logic             uart_tx,
    input  logic             uart_rx
);

    localparam int             CW        = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]     IDX_LAST  = 3'(DATA_BITS - 1);

    uart_state_t   tx_state, tx_state_d, rx_state, rx_state_d;
    logic [CW-1:0] tx_cnt, tx_cnt_d, rx_cnt, rx_cnt_d;
    logic [2:0]    tx_bit, tx_bit_d, rx_bit, rx_bit_d;
    logic [7:0]    tx_sh, tx_sh_d, rx_sh, rx_sh_d, load_byte;
    logic          tx_end, load, tx_line_d, rx_meta, rx, rx_tick, push;

    assign tx_end = tx_cnt == BIT_LAST;

`ifdef UART_TX_HOLD_EN
    logic [7:0] hold;
    logic       hold_v, fire;
    // shifter frees up next cycle: idle now, or last cycle of the stop bit
    assign fire          = tx_state == IDLE || (tx_state == STOP && tx_end);
    assign load          = fire && (hold_v || bus.uart0_wr);
    assign load_byte     = hold_v ? hold : bus.uart_w;
    assign bus.tx_busy   = tx_state != IDLE && hold_v;
    always_ff @(posedge clk or negedge resetq)
        if (!resetq) begin
            hold_v <= 1'b0;
            hold   <= '0;
        end else begin
            hold_v <= hold_v ? !fire : bus.uart0_wr && !fire;
            if (!hold_v && bus.uart0_wr) hold <= bus.uart_w;
        end
`else
    assign load          = tx_state == IDLE && bus.uart0_wr;
    assign load_byte     = bus.uart_w;
    assign bus.tx_busy   = tx_state != IDLE;
`endif

    always_comb begin
        tx_state_d = tx_state;
        tx_sh_d    = tx_sh;
        tx_bit_d   = tx_bit;
        tx_cnt_d   = (tx_state == IDLE || tx_end) ? '0 : tx_cnt + 1'b1;
        case (tx_state)
            IDLE:  ;
            START: if (tx_end) tx_state_d = DATA;
            DATA:  if (tx_end) begin
                tx_sh_d  = tx_sh >> 1;
                tx_bit_d = tx_bit + 1'b1;
                if (tx_bit == IDX_LAST) tx_state_d = STOP;
            end
            STOP:  if (tx_end) tx_state_d = IDLE;
        endcase
        if (load) begin
            tx_state_d = START;
            tx_sh_d    = load_byte;
            tx_cnt_d   = '0;
        end
        tx_line_d = tx_state_d == START ? 1'b0 : tx_state_d == DATA ? tx_sh_d[0] :
                    tx_state_d == STOP ? STOP_LEVEL : IDLE_LEVEL;
    end

    always_comb begin
        rx_state_d = rx_state;
        rx_sh_d    = rx_sh;
        rx_bit_d   = rx_bit;
        push       = 1'b0;
        rx_tick    = rx_cnt == (rx_state == START ? HALF_LAST : BIT_LAST);
        rx_cnt_d   = (rx_state == IDLE || rx_tick) ? '0 : rx_cnt + 1'b1;
        case (rx_state)
            IDLE:  if (rx != IDLE_LEVEL) rx_state_d = START;
            START: if (rx_tick) rx_state_d = rx ? IDLE : DATA;
            DATA:  if (rx_tick) begin
                rx_sh_d  = {rx, rx_sh[7:1]};
                rx_bit_d = rx_bit + 1'b1;
                if (rx_bit == IDX_LAST) rx_state_d = STOP;
            end
            STOP:  if (rx_tick) begin
                push       = rx == STOP_LEVEL;
                rx_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetq)
        if (!resetq) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            uart_tx  <= IDLE_LEVEL;
            rx_meta  <= 1'b1;
            rx       <= 1'b1;
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
        end else begin
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_bit   <= tx_bit_d;
            tx_sh    <= tx_sh_d;
            uart_tx  <= tx_line_d;
            rx_meta  <= uart_rx;
            rx       <= rx_meta;
            rx_state <= rx_state_d;
            rx_cnt   <= rx_cnt_d;
            rx_bit   <= rx_bit_d;
            rx_sh    <= rx_sh_d;
        end

    uart_rx_fifo #(.DEPTH(RX_DEPTH)) u_fifo (
        .clk      (clk),
        .resetq   (resetq),
        .push     (push),
        .din      (rx_sh),
        .pop      (bus.uart0_rd),
        .head     (bus.uart0_data),
        .valid    (bus.rx_valid),
        .overflow (bus.rx_overflow)
    );

endmodule

// File: tb/tb_uart_responder.sv
// tb_uart_responder: directed checks of uart_responder with CLKS_PER_BIT=4, RX_DEPTH=4.
module tb_uart_responder;

    logic clk = 1'b0, resetq = 1'b1, loop = 1'b0, rx_drv = 1'b1;
    logic uart_tx, uart_rx;
    int   checks = 0, failures = 0, ovf_cnt = 0;

    uart_responder_if bus();

    uart_responder #(.CLKS_PER_BIT(4), .RX_DEPTH(4)) dut (
        .clk     (clk),
        .resetq  (resetq),
        .bus     (bus),
        .uart_tx (uart_tx),
        .uart_rx (uart_rx)
    );

    assign uart_rx = loop ? uart_tx : rx_drv;

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.rx_overflow) ovf_cnt <= ovf_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // expected line at cycle c (1-based) of a frame started by a strobe at cycle 0
    function automatic logic frame_bit(input logic [7:0] b, input int c);
        if (c <= 4) return 1'b0;
        if (c <= 36) return b[(c - 5) / 4];
        return 1'b1;
    endfunction

    task automatic tx_write(input logic [7:0] b);
        bus.uart_w   = b;
        bus.uart0_wr = 1'b1;
        tick(1);
        bus.uart0_wr = 1'b0;
    endtask

    task automatic pop();
        bus.uart0_rd = 1'b1;
        tick(1);
        bus.uart0_rd = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx_drv = 1'b0;
        tick(4);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            tick(4);
        end
        rx_drv = stop;
        tick(4);
        rx_drv = 1'b1;
        tick(4);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic exp;
        bus.uart0_wr = 1'b0;
        bus.uart0_rd = 1'b0;
        bus.uart_w   = 8'h00;
        #2 resetq = 1'b0;
        tick(3);
        check("rst_tx", uart_tx, 1);
        check("rst_busy", bus.tx_busy, 0);
        check("rst_valid", bus.rx_valid, 0);
        check("rst_data", bus.uart0_data, 0);
        check("rst_ovf", bus.rx_overflow, 0);
        resetq = 1'b1;
        tick(2);

        tx_write(8'h55);
        for (int c = 1; c <= 40; c++) begin
            check("tx55", uart_tx, frame_bit(8'h55, c));
            if (c == 1 || c == 40) check("busy55", bus.tx_busy, 1);
            tick(1);
        end
        check("busy55_end", bus.tx_busy, 0);
        check("tx55_idle", uart_tx, 1);

        loop = 1'b1;
        tx_write(8'hA3);
        for (int i = 0; i < 60 && !bus.rx_valid; i++) tick(1);
        check("lb_valid", bus.rx_valid, 1);
        check("lb_data", bus.uart0_data, 8'hA3);
        tick(4);
        pop();
        check("lb_pop_valid", bus.rx_valid, 0);
        check("lb_pop_data", bus.uart0_data, 0);
        loop = 1'b0;
        tick(4);

        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1);
            if (i == 4) check("fill_no_ovf", ovf_cnt, 0);
        end
        check("ovf_once", ovf_cnt, 1);
        for (int i = 1; i <= 4; i++) begin
            check("drain_valid", bus.rx_valid, 1);
            check("drain_data", bus.uart0_data, i);
            pop();
        end
        check("drain_empty", bus.rx_valid, 0);
        pop();
        check("pop_empty_data", bus.uart0_data, 0);

        rx_drv = 1'b0;
        tick(1);
        rx_drv = 1'b1;
        tick(20);
        check("glitch", bus.rx_valid, 0);

        send_frame(8'h7E, 1'b0);
        tick(8);
        check("framing", bus.rx_valid, 0);
        send_frame(8'h5A, 1'b1);
        check("after_frm_valid", bus.rx_valid, 1);
        check("after_frm_data", bus.uart0_data, 8'h5A);
        pop();
        check("after_frm_pop", bus.rx_valid, 0);

        tx_write(8'h12);
        for (int c = 1; c <= 88; c++) begin
`ifdef UART_TX_HOLD_EN
            exp = c <= 40 ? frame_bit(8'h12, c) : c <= 80 ? frame_bit(8'h34, c - 40) : 1'b1;
            if (c == 1) check("dbl_busy1", bus.tx_busy, 0);
`else
            exp = c <= 40 ? frame_bit(8'h12, c) : 1'b1;
            if (c == 1) check("dbl_busy1", bus.tx_busy, 1);
`endif
            check("dbl_tx", uart_tx, exp);
            if (c == 3) check("dbl_busy3", bus.tx_busy, 1);
            if (c == 41) check("dbl_busy41", bus.tx_busy, 0);
            bus.uart_w   = 8'h34;
            bus.uart0_wr = c == 2;
            tick(1);
        end
        bus.uart0_wr = 1'b0;
        tick(4);

        send_frame(8'h33, 1'b1);
        check("prerst_valid", bus.rx_valid, 1);
        tx_write(8'h00);
        tick(14);
        check("prerst_tx", uart_tx, 0);
        resetq = 1'b0;
        #1;
        check("rst_mid_tx", uart_tx, 1);
        check("rst_mid_busy", bus.tx_busy, 0);
        check("rst_mid_valid", bus.rx_valid, 0);
        tick(2);
        resetq = 1'b1;
        for (int c = 0; c < 20; c++) begin
            check("post_rst_tx", uart_tx, 1);
            tick(1);
        end
        check("post_rst_busy", bus.tx_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
